wr_burst_ctrl: RTL and testbench

Parametrised Avalon-MM burst write master that drains a show-ahead packet FIFO into memory. It replaces the single-burst writer with one that splits a packet of arbitrary length into bursts of at most MAX_BURST beats. It tracks address and remaining beats across bursts, reports completion and errors, and sits between the packet FIFO and the SDRAM/HPS write port.

---
 rtl/wr_ctrl_pkg.sv | 27 ++
 rtl/wr_burst_planner.sv | 37 +++
 rtl/wr_burst_ctrl.sv | 118 +++++++++++
 tb/tb_wr_burst_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_ctrl_pkg.sv
// Shared state encoding, default word geometry and helpers for the wr_burst_ctrl write master.
package wr_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAN  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    PLAN  = S_PLAN,
    BURST = S_BURST,
    DONE  = S_DONE
  } state_t;

  // Geometry of the default 32-bit data path; modules derive their own from DATA_W.
  localparam int unsigned BPW      = 4;
  localparam int unsigned BPW_LOG2 = 2;

  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/wr_burst_planner.sv
// Combinational burst-length planner for wr_burst_ctrl.
// Define WR_BURST_BOUNDARY_EN to stop bursts crossing a MAX_BURST-word aligned boundary.
module wr_burst_planner
  import wr_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BC_W      = 16
) (
  input  logic [31:0]       remaining_beats,
  input  logic [ADDR_W-1:0] cur_addr,
  output logic [BC_W-1:0]   burst_len
);

  logic [31:0] room;

`ifdef WR_BURST_BOUNDARY_EN
  localparam int unsigned WORD_SHIFT = $clog2(DATA_W / 8);
  logic [ADDR_W-1:0] word_idx;

  // Words left before the next MAX_BURST-aligned word boundary.
  always_comb begin
    word_idx = cur_addr >> WORD_SHIFT;
    room     = 32'(MAX_BURST) - 32'(word_idx & ADDR_W'(MAX_BURST - 1));
  end
`else
  localparam int unsigned unused_bpw = DATA_W / 8;
  logic unused_addr;

  assign unused_addr = ^cur_addr;
  assign room        = 32'(MAX_BURST);
`endif

  assign burst_len = BC_W'(min3(32'(MAX_BURST), remaining_beats, room));

endmodule

// File: rtl/wr_burst_ctrl.sv
// Avalon-MM burst write master: drains a show-ahead FIFO into memory, splitting a packet into
// bursts of at most MAX_BURST beats. Define WR_BURST_BOUNDARY_EN for boundary-aligned bursts.
module wr_burst_ctrl
  import wr_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BC_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_ctrl,
  input  logic [31:0]         pkt_begin,
  input  logic [31:0]         pkt_end,
  input  logic [ADDR_W-1:0]   write_address,
  input  logic                empty,
  input  logic [DATA_W-1:0]   fifo_out,
  output logic                rd_from_fifo,
  output logic                busy,
  output logic                wr_ctrl_rdy,
  output logic                err,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   writedata,
  output logic                write,
  output logic [BC_W-1:0]     burstcount,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest
);

  localparam int unsigned WORD_BYTES = DATA_W / 8;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       remaining_beats;
  logic [BC_W-1:0]   beat_cnt;
  logic [BC_W-1:0]   burst_len;
  logic              len_neg;
  logic [31:0]       len_bytes;
  logic              beat_ok;

  assign len_bytes    = pkt_end - pkt_begin;
  assign write        = (state == BURST) && !empty;
  assign beat_ok      = write && !waitrequest;
  assign rd_from_fifo = beat_ok;
  assign writedata    = fifo_out;
  assign byteenable   = '1;

  wr_burst_planner #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST),
    .BC_W      (BC_W)
  ) u_planner (
    .remaining_beats (remaining_beats),
    .cur_addr        (cur_addr),
    .burst_len       (burst_len)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      wr_ctrl_rdy     <= 1'b0;
      err             <= 1'b0;
      address         <= '0;
      burstcount      <= '0;
      cur_addr        <= '0;
      remaining_beats <= '0;
      beat_cnt        <= '0;
      len_neg         <= 1'b0;
    end else begin
      wr_ctrl_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ctrl) begin
            cur_addr        <= write_address;
            remaining_beats <= len_bytes >> WORD_SHIFT;
            len_neg         <= pkt_end < pkt_begin;
            err             <= (pkt_end < pkt_begin) ||
                               ((len_bytes & 32'(WORD_BYTES - 1)) != '0);
            busy            <= 1'b1;
            state           <= PLAN;
          end
        end
        PLAN: begin
          if (remaining_beats == '0 || len_neg) begin
            state <= DONE;
          end else begin
            address    <= cur_addr;
            burstcount <= burst_len;
            beat_cnt   <= burst_len;
            state      <= BURST;
          end
        end
        BURST: begin
          if (beat_ok) begin
            beat_cnt        <= beat_cnt - BC_W'(1);
            remaining_beats <= remaining_beats - 32'd1;
            // burstcount still holds this burst's length, so it gives the address step.
            if (beat_cnt == BC_W'(1)) begin
              cur_addr <= cur_addr + (ADDR_W'(burstcount) << WORD_SHIFT);
              state    <= (remaining_beats == 32'd1) ? DONE : PLAN;
            end
          end
        end
        DONE: begin
          wr_ctrl_rdy <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Self-checking bench for wr_burst_ctrl: randomized FIFO/stall stimulus against a packet-level model.
module tb_wr_burst_ctrl;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned BC_W      = 16;
  localparam int unsigned BPW       = 4;
`ifdef WR_BURST_BOUNDARY_EN
  localparam bit BOUNDARY = 1'b1;
`else
  localparam bit BOUNDARY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_ctrl = 1'b0;
  logic [31:0] pkt_begin = '0;
  logic [31:0] pkt_end = '0;
  logic [31:0] write_address = '0;
  logic        empty = 1'b1;
  logic [31:0] fifo_out = '0;
  logic        waitrequest = 1'b0;
  logic        rd_from_fifo, busy, wr_ctrl_rdy, err, write;
  logic [31:0] address, writedata;
  logic [15:0] burstcount;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  wr_burst_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST),
    .BC_W      (BC_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_ctrl       (wr_ctrl),
    .pkt_begin     (pkt_begin),
    .pkt_end       (pkt_end),
    .write_address (write_address),
    .empty         (empty),
    .fifo_out      (fifo_out),
    .rd_from_fifo  (rd_from_fifo),
    .busy          (busy),
    .wr_ctrl_rdy   (wr_ctrl_rdy),
    .err           (err),
    .address       (address),
    .writedata     (writedata),
    .write         (write),
    .burstcount    (burstcount),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] q[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  int unsigned exp_bc[$];
  logic [31:0] obs_data[$];
  logic [31:0] obs_addr[$];
  logic [15:0] obs_bc[$];

  int unsigned pop_cnt = 0, rdy_cnt = 0, stall_viol = 0, pop_empty_viol = 0;
  int unsigned wr_pct = 0, emp_pct = 0;
  bit          do_pop = 1'b0, was_stalled = 1'b0, force_empty = 1'b0;
  logic [31:0] held_data = '0;

  // One clock: observe the bus mid-cycle, then update the FIFO model just after the edge.
  task automatic tick();
    @(negedge clk);
    do_pop = 1'b0;
    if (reset) begin
      if (write && !waitrequest) begin
        obs_data.push_back(writedata);
        obs_addr.push_back(address);
        obs_bc.push_back(burstcount);
      end
      if (rd_from_fifo) begin
        pop_cnt++;
        do_pop = 1'b1;
      end
      if (rd_from_fifo && empty) pop_empty_viol++;
      if (was_stalled && (!write || writedata !== held_data)) stall_viol++;
      if (wr_ctrl_rdy) rdy_cnt++;
      was_stalled = write && waitrequest;
      held_data   = writedata;
    end
    @(posedge clk);
    #1;
    if (do_pop && q.size() > 0) q.delete(0);
    if (!was_stalled) force_empty = ($urandom_range(99) < emp_pct);
    waitrequest = ($urandom_range(99) < wr_pct);
    empty       = force_empty || (q.size() == 0);
    fifo_out    = (q.size() == 0) ? 32'hDEAD_BEEF : q[0];
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_addr.delete();
    obs_bc.delete();
    pop_cnt = 0;
    rdy_cnt = 0;
    stall_viol = 0;
    pop_empty_viol = 0;
  endtask

  // Packet-level model: list of per-beat burst start address and burst length.
  task automatic build_expected(input logic [31:0] addr, input int unsigned nb);
    logic [31:0] a;
    int unsigned r, room, l;
    a = addr;
    r = nb;
    exp_addr.delete();
    exp_bc.delete();
    while (r > 0) begin
      room = BOUNDARY ? (MAX_BURST - ((a / BPW) % MAX_BURST)) : MAX_BURST;
      l = MAX_BURST;
      if (r < l) l = r;
      if (room < l) l = room;
      for (int unsigned i = 0; i < l; i++) begin
        exp_addr.push_back(a);
        exp_bc.push_back(l);
      end
      a = a + l * BPW;
      r = r - l;
    end
  endtask

  task automatic run_pkt(input string name, input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] addr, input bit poke);
    int unsigned nb, cyc;
    logic exp_err;
    logic [31:0] w;
    exp_err = (e < b) || (((e - b) % BPW) != 0);
    nb = (e < b) ? 0 : (e - b) / BPW;
    build_expected(addr, nb);
    q.delete();
    exp_data.delete();
    clear_obs();
    for (int unsigned i = 0; i < nb; i++) begin
      w = $urandom;
      q.push_back(w);
      exp_data.push_back(w);
    end
    pkt_begin = b;
    pkt_end = e;
    write_address = addr;
    wr_ctrl = 1'b1;
    tick();
    wr_ctrl = 1'b0;
    pkt_begin = $urandom;
    pkt_end = $urandom;
    write_address = $urandom;
    cyc = 0;
    while (rdy_cnt == 0 && cyc < 5000) begin
      tick();
      cyc++;
      wr_ctrl = poke && (cyc == 4);
    end
    wr_ctrl = 1'b0;
    n_cmp++;
    if (rdy_cnt == 0) begin
      n_bad++;
      $display("FAIL %s done_timeout: no wr_ctrl_rdy after %0d cycles, required within 5000",
               name, cyc);
    end
    repeat (3) tick();
    n_cmp++;
    if (rdy_cnt !== 1) begin
      n_bad++;
      $display("FAIL %s rdy_pulses: got %0d, expected 1", name, rdy_cnt);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_bad++;
      $display("FAIL %s err: got %b, expected %b", name, err, exp_err);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_after_done: got %b, expected 0", name, busy);
    end
    n_cmp++;
    if (obs_data.size() !== nb) begin
      n_bad++;
      $display("FAIL %s beats: got %0d, expected %0d", name, obs_data.size(), nb);
    end
    n_cmp++;
    if (pop_cnt !== nb) begin
      n_bad++;
      $display("FAIL %s pops: got %0d, expected %0d", name, pop_cnt, nb);
    end
    n_cmp++;
    if (stall_viol !== 0) begin
      n_bad++;
      $display("FAIL %s stall_hold: %0d unstable stalled cycles, expected 0", name, stall_viol);
    end
    n_cmp++;
    if (pop_empty_viol !== 0) begin
      n_bad++;
      $display("FAIL %s pop_when_empty: %0d, expected 0", name, pop_empty_viol);
    end
    for (int unsigned i = 0; i < nb && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i]) begin
        n_bad++;
        $display("FAIL %s data[%0d]: got %h, expected %h", name, i, obs_data[i], exp_data[i]);
      end
      n_cmp++;
      if (obs_addr[i] !== exp_addr[i]) begin
        n_bad++;
        $display("FAIL %s address[%0d]: got %h, expected %h", name, i, obs_addr[i], exp_addr[i]);
      end
      n_cmp++;
      if (obs_bc[i] !== 16'(exp_bc[i])) begin
        n_bad++;
        $display("FAIL %s burstcount[%0d]: got %0d, expected %0d", name, i, obs_bc[i], exp_bc[i]);
      end
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, wr_ctrl_rdy, err, write, rd_from_fifo} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: busy/rdy/err/write/rd = %b, expected 00000",
               {busy, wr_ctrl_rdy, err, write, rd_from_fifo});
    end
    n_cmp++;
    if (address !== 32'h0 || burstcount !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_regs: address %h burstcount %0d, expected 0 and 0", address, burstcount);
    end
    n_cmp++;
    if (byteenable !== 4'hF) begin
      n_bad++;
      $display("FAIL byteenable: got %h, expected f", byteenable);
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int unsigned k, first_wr, first_rdy;
    bit wr_seen;
    wr_pct = 0;
    emp_pct = 0;
    q.delete();
    clear_obs();
    for (int unsigned i = 0; i < 4; i++) q.push_back($urandom);
    tick();
    pkt_begin = 32'h0;
    pkt_end = 32'h10;
    write_address = 32'h200;
    wr_ctrl = 1'b1;
    k = 0;
    first_wr = 0;
    while (first_wr == 0 && k < 20) begin
      tick();
      wr_ctrl = 1'b0;
      k++;
      if (k == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_after_start: got %b, expected 1", busy);
        end
      end
      if (write) first_wr = k;
    end
    n_cmp++;
    if (first_wr !== 2) begin
      n_bad++;
      $display("FAIL write_latency: got %0d cycles, expected 2", first_wr);
    end
    k = 0;
    while (rdy_cnt == 0 && k < 100) begin
      tick();
      k++;
    end
    tick();
    pkt_begin = 32'h80;
    pkt_end = 32'h80;
    wr_ctrl = 1'b1;
    k = 0;
    first_rdy = 0;
    wr_seen = 1'b0;
    while (first_rdy == 0 && k < 20) begin
      tick();
      wr_ctrl = 1'b0;
      k++;
      if (write) wr_seen = 1'b1;
      if (wr_ctrl_rdy) first_rdy = k;
    end
    n_cmp++;
    if (first_rdy !== 3) begin
      n_bad++;
      $display("FAIL zero_len_rdy_latency: got %0d cycles, expected 3", first_rdy);
    end
    n_cmp++;
    if (wr_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_len_write: write seen %b, expected 0", wr_seen);
    end
    repeat (2) tick();
  endtask

  task automatic test_full_packet();
    wr_pct = 0;
    emp_pct = 0;
    run_pkt("full256_poke", 32'h0, 32'h100, 32'h1000, 1'b1);
    run_pkt("len40", 32'h0, 32'd40, 32'h1000, 1'b0);
  endtask

  task automatic test_stall();
    wr_pct = 35;
    emp_pct = 25;
    run_pkt("stall256", 32'h0, 32'h100, 32'h1000, 1'b0);
    run_pkt("stall40", 32'h20, 32'h48, 32'h2004, 1'b0);
    run_pkt("stall148", 32'd12, 32'd160, 32'h3ff8, 1'b0);
    wr_pct = 0;
    emp_pct = 0;
  endtask

  task automatic test_errors();
    run_pkt("end_lt_begin", 32'd100, 32'd50, 32'h3000, 1'b0);
    run_pkt("len42", 32'h0, 32'd42, 32'h3000, 1'b0);
    run_pkt("err_clears", 32'h0, 32'd8, 32'h3100, 1'b0);
  endtask

  task automatic test_boundary();
    run_pkt("addr1030_32beats", 32'h0, 32'h80, 32'h1030, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] b, e, a;
    for (int unsigned i = 0; i < 12; i++) begin
      b = $urandom_range(1000, 100);
      if ((i % 6) == 5) e = b - $urandom_range(99, 1);
      else e = b + $urandom_range(400, 0);
      if ((i % 4) == 0) a = 32'hFFFF_FF00 + 4 * $urandom_range(63, 0);
      else a = $urandom & 32'hFFFF_FFFC;
      wr_pct = $urandom_range(40, 0);
      emp_pct = $urandom_range(30, 0);
      run_pkt($sformatf("rand%0d", i), b, e, a, 1'b0);
    end
    wr_pct = 0;
    emp_pct = 0;
  endtask

  task automatic test_back_to_back();
    run_pkt("b2b_a", 32'h0, 32'h44, 32'h6000, 1'b1);
    run_pkt("b2b_b", 32'h0, 32'h20, 32'h603c, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int unsigned cyc;
    q.delete();
    clear_obs();
    for (int unsigned i = 0; i < 64; i++) q.push_back($urandom);
    pkt_begin = 32'h0;
    pkt_end = 32'h100;
    write_address = 32'h4000;
    wr_ctrl = 1'b1;
    tick();
    wr_ctrl = 1'b0;
    cyc = 0;
    while (obs_data.size() < 5 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (obs_data.size() < 5) begin
      n_bad++;
      $display("FAIL rst_mid_progress: %0d beats after %0d cycles, expected at least 5",
               obs_data.size(), cyc);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (write !== 1'b0 || busy !== 1'b0 || rd_from_fifo !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: write %b busy %b rd %b, expected 0 0 0",
               write, busy, rd_from_fifo);
    end
    n_cmp++;
    if (burstcount !== 16'h0 || address !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_regs: burstcount %0d address %h, expected 0 and 0",
               burstcount, address);
    end
    repeat (2) tick();
    q.delete();
    was_stalled = 1'b0;
    reset = 1'b1;
    tick();
    run_pkt("after_reset", 32'h0, 32'h40, 32'h5000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_packet();
    test_stall();
    test_errors();
    test_boundary();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
